// File: rtl/dest_history_match_if.sv
// Bundle of the write, control, query and result signals of dest_history_match.
// The master drives writes and queries. The slave returns registered hit results.
interface dest_history_match_if #(
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 3,
  parameter int NUM_SRC = 2
);
  localparam int AGE_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // wr_valid qualifies wr_addr for one cycle; there is no ready, a write is
  // consumed on every non-stalled, non-flushed edge and dropped otherwise.
  logic                        wr_valid;
  logic [ADDR_W-1:0]           wr_addr;
  logic                        stall;
  logic                        flush;
  logic [NUM_SRC*ADDR_W-1:0]   src_addr;
  logic [NUM_SRC-1:0]          hit;
  logic [NUM_SRC*AGE_W-1:0]    hit_age;

  modport master (
    output wr_valid, wr_addr, stall, flush, src_addr,
    input  hit, hit_age
  );

  modport slave (
    input  wr_valid, wr_addr, stall, flush, src_addr,
    output hit, hit_age
  );
endinterface

// File: rtl/dest_history_match.sv
// Shift-register history of recent destination writes with per-channel
// source-address match lookup. It returns a registered hit flag and the age of
// the youngest matching entry.
module dest_history_match #(
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 3,
  parameter int NUM_SRC   = 2,
  parameter int ZERO_EXCL = 1,
  parameter int ZERO_REG  = 31,
  localparam int AGE_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dest_history_match_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  // Entry 0 is the youngest write and entry DEPTH-1 is the oldest.
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [ADDR_W-1:0]       addr_q [DEPTH];
  logic [ADDR_W-1:0]       addr_d [DEPTH];
  logic [NUM_SRC-1:0]      hit_q, hit_d;
  logic [NUM_SRC*AGE_W-1:0] hit_age_q, hit_age_d;

  // Next history: flush clears, stall holds, otherwise shift in the write slot (bubbles included)
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (bus.flush) begin
      valid_d = '0;
    end else if (!bus.stall) begin
      valid_d[0] = bus.wr_valid;
      addr_d[0]  = bus.wr_addr;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        addr_d[i]  = addr_q[i-1];
      end
    end
  end

  // Per-channel lookup against the pre-edge history; scanning oldest to youngest lets the youngest match win
  always_comb begin
    hit_d     = '0;
    hit_age_d = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!((ZERO_EXCL != 0) && (bus.src_addr[k*ADDR_W +: ADDR_W] == ZERO_ADDR))) begin
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (valid_q[i] && (addr_q[i] == bus.src_addr[k*ADDR_W +: ADDR_W])) begin
            hit_d[k]                     = 1'b1;
            hit_age_d[k*AGE_W +: AGE_W]  = AGE_W'(i);
          end
        end
      end
    end
    if (bus.flush) begin
      hit_d     = '0;
      hit_age_d = '0;
    end
  end

  // Valid bits and registered results, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      hit_q     <= '0;
      hit_age_q <= '0;
    end else begin
      valid_q   <= valid_d;
      hit_q     <= hit_d;
      hit_age_q <= hit_age_d;
    end
  end

  // Address payload needs no reset because the valid bits gate every use of it
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign bus.hit     = hit_q;
  assign bus.hit_age = hit_age_q;

endmodule
